qmax_argmax_stream: RTL and testbench
=====================================

Name: qmax_argmax_stream

Overview:
- Sequential, parametrised successor to the combinational 9-input 18-bit Q-value max tree.
- Accepts NUM_ACTIONS Q-values serially over a valid/ready stream, one per action index, each tagged with a legal-move bit.
- Returns the maximum legal Q-value, its action index, and a no-legal-move flag.
- Sits between the Q-table read port and the move-selection / Q-update logic of the tic-tac-toe agent.

Parameters:
- Q_WIDTH, 18, bit width of each Q-value.
- NUM_ACTIONS, 9, beats per evaluation (board cells).
- IDX_WIDTH, 4, width of action index; must satisfy 2^IDX_WIDTH >= NUM_ACTIONS.
- SIGNED_Q, 0, 1 = Q-values compared as two's complement; 0 = unsigned.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins an evaluation; honoured only in IDLE.
- in_valid  input  1  in_q/in_legal valid.
- in_ready  output  1  block accepts a beat.
- in_q  input  Q_WIDTH  Q-value for the current action index.
- in_legal  input  1  1 = cell empty / move allowed.
- busy  output  1  high in ACCUM or DONE.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- max_q  output  Q_WIDTH  maximum legal Q-value.
- max_idx  output  IDX_WIDTH  index (0-based beat number) of max_q.
- none_legal  output  1  no beat had in_legal=1.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All outputs 0, including in_ready, out_valid, max_q, max_idx, none_legal and busy.
  - Beat counter and internal best registers cleared.
- State IDLE:
  - in_ready=0, out_valid=0.
  - start=1 -> ACCUM next cycle: counter=0, best_valid=0, best_q=0, best_idx=0.
- State ACCUM:
  - in_ready=1; a beat is accepted when in_valid & in_ready.
  - Accepted beat with in_legal=1: update best if best_valid=0 or in_q > best_q (strict; signedness per SIGNED_Q). Then best_valid=1 and best_idx=counter.
  - Ties keep the earlier (lower) index.
  - Illegal beats are ignored for comparison but still counted.
  - Counter increments per accepted beat. On the accepted beat with counter==NUM_ACTIONS-1 -> DONE; that beat is included in the result.
  - in_ready drops to 0 in the cycle after the last beat.
  - start is ignored in ACCUM and DONE.
- State DONE:
  - out_valid=1; max_q=best_q, max_idx=best_idx, none_legal=~best_valid.
  - When none_legal=1, max_q=0 and max_idx=0.
  - Outputs stay stable while out_valid & ~out_ready.
  - out_valid & out_ready -> IDLE next cycle; out_valid deasserts then.
  - A start in the same cycle as the output handshake is ignored.
- Latency: out_valid rises 1 cycle after the last accepted beat. Minimum evaluation is NUM_ACTIONS+2 cycles from start to out_valid (1 cycle start->ACCUM, NUM_ACTIONS beats, 1 cycle to DONE).
- Outputs are registered; no combinational path from in_* to out_*.
- in_valid gaps (bubbles) are allowed; there is no timeout.
- Reset mid-evaluation discards all partial state immediately.
- Widths: the counter is IDX_WIDTH bits and never wraps, because the transition to DONE occurs at NUM_ACTIONS-1.

Optional Feature:
- Macro QMAX_LEGAL_COUNT_EN.
- Defined:
  - Adds output port legal_cnt (IDX_WIDTH bits): number of accepted beats with in_legal=1 in the current evaluation.
  - Reset value 0; cleared on start; valid and stable in DONE alongside out_valid.
  - none_legal equals (legal_cnt==0).
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults, all legal, in_q = 5,17,3,99,42,99,0,1,8 with no bubbles -> out_valid 11 cycles after start; max_q=99, max_idx=3 (tie keeps lower index); none_legal=0.
- Same values, in_legal=0 for beats 3 and 5 -> max_q=42, max_idx=4, none_legal=0; legal_cnt=7 with QMAX_LEGAL_COUNT_EN.
- All in_legal=0 -> none_legal=1, max_q=0, max_idx=0; legal_cnt=0 with QMAX_LEGAL_COUNT_EN.
- SIGNED_Q=1, in_q = -1 (0x3FFFF), -5, -2, then six beats of -7, all legal -> max_q=0x3FFFF, max_idx=0. Same stimulus with SIGNED_Q=0 -> same max_q and max_idx, because 0x3FFFF is the largest unsigned value and the lower index wins.
- Random in_valid bubbles plus out_ready held low for 5 cycles in DONE -> result matches the bubble-free run; outputs stable while stalled; a start pulse during ACCUM or the stall has no effect.
- rst_n pulsed low after beat 4 -> all outputs 0 immediately; a fresh start then evaluates correctly with no carry-over of best_q.

Source files
------------

// File: rtl/qmax_argmax_stream.sv
// Streaming argmax over NUM_ACTIONS Q-values with legal-move masking; one beat per action index.
// Optional QMAX_LEGAL_COUNT_EN adds a legal_cnt output counting legal beats per evaluation.
module qmax_argmax_stream #(
  parameter int Q_WIDTH     = 18,
  parameter int NUM_ACTIONS = 9,
  parameter int IDX_WIDTH   = 4,
  parameter int SIGNED_Q    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [Q_WIDTH-1:0]   in_q,
  input  logic                 in_legal,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Q_WIDTH-1:0]   max_q,
  output logic [IDX_WIDTH-1:0] max_idx,
`ifdef QMAX_LEGAL_COUNT_EN
  output logic [IDX_WIDTH-1:0] legal_cnt,
`endif
  output logic                 none_legal
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ACTIONS - 1);

  state_t               state_q;
  logic [IDX_WIDTH-1:0] cnt_q;
  logic [Q_WIDTH-1:0]   best_q_q, best_q_d;
  logic [IDX_WIDTH-1:0] best_idx_q, best_idx_d;
  logic                 best_valid_q, best_valid_d;
  logic                 in_ready_q, busy_q, out_valid_q, none_legal_q;
  logic [Q_WIDTH-1:0]   max_q_q;
  logic [IDX_WIDTH-1:0] max_idx_q;
  logic                 beat_acc, legal_acc, q_gt, take;

  generate
    if (SIGNED_Q != 0) begin : g_signed
      assign q_gt = $signed(in_q) > $signed(best_q_q);
    end else begin : g_unsigned
      assign q_gt = in_q > best_q_q;
    end
  endgenerate

  // in_ready_q is only ever high in ACCUM, so it doubles as the state qualifier
  assign beat_acc  = in_valid & in_ready_q;
  assign legal_acc = beat_acc & in_legal;
  assign take      = legal_acc & (~best_valid_q | q_gt);

  always_comb begin
    best_q_d     = take ? in_q  : best_q_q;
    best_idx_d   = take ? cnt_q : best_idx_q;
    best_valid_d = best_valid_q | legal_acc;
  end

`ifdef QMAX_LEGAL_COUNT_EN
  logic [IDX_WIDTH-1:0] legal_cnt_q, legal_cnt_d;
  assign legal_cnt_d = legal_cnt_q + IDX_WIDTH'(legal_acc);
  assign legal_cnt   = legal_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      best_q_q     <= '0;
      best_idx_q   <= '0;
      best_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      max_q_q      <= '0;
      max_idx_q    <= '0;
      none_legal_q <= 1'b0;
`ifdef QMAX_LEGAL_COUNT_EN
      legal_cnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= ACCUM;
            cnt_q        <= '0;
            best_q_q     <= '0;
            best_idx_q   <= '0;
            best_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b1;
`ifdef QMAX_LEGAL_COUNT_EN
            legal_cnt_q  <= '0;
`endif
          end
        end
        ACCUM: begin
          if (beat_acc) begin
            cnt_q        <= cnt_q + IDX_WIDTH'(1);
            best_q_q     <= best_q_d;
            best_idx_q   <= best_idx_d;
            best_valid_q <= best_valid_d;
`ifdef QMAX_LEGAL_COUNT_EN
            legal_cnt_q  <= legal_cnt_d;
`endif
            // The final beat folds straight into the registered result
            if (cnt_q == LAST_IDX) begin
              state_q      <= DONE;
              in_ready_q   <= 1'b0;
              out_valid_q  <= 1'b1;
              max_q_q      <= best_q_d;
              max_idx_q    <= best_idx_d;
              none_legal_q <= ~best_valid_d;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign max_q      = max_q_q;
  assign max_idx    = max_idx_q;
  assign none_legal = none_legal_q;

endmodule

// File: tb/tb_qmax_argmax_stream.sv
// Scoreboard bench: drives unsigned and signed instances with identical directed vectors,
// a monitor pops expected results on each output handshake.
module tb_qmax_argmax_stream;

  localparam int QW = 18;
  localparam int NA = 9;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_legal = 1'b0;
  logic          out_ready = 1'b1;
  logic [QW-1:0] in_q = '0;

  logic          in_ready_u, busy_u, out_valid_u, none_legal_u;
  logic [QW-1:0] max_q_u;
  logic [IW-1:0] max_idx_u;
  logic          in_ready_s, busy_s, out_valid_s, none_legal_s;
  logic [QW-1:0] max_q_s;
  logic [IW-1:0] max_idx_s;
`ifdef QMAX_LEGAL_COUNT_EN
  logic [IW-1:0] legal_cnt_u, legal_cnt_s;
`endif

  qmax_argmax_stream #(.Q_WIDTH(QW), .NUM_ACTIONS(NA), .IDX_WIDTH(IW), .SIGNED_Q(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_q(in_q), .in_legal(in_legal), .busy(busy_u), .out_valid(out_valid_u),
    .out_ready(out_ready), .max_q(max_q_u), .max_idx(max_idx_u),
`ifdef QMAX_LEGAL_COUNT_EN
    .legal_cnt(legal_cnt_u),
`endif
    .none_legal(none_legal_u)
  );

  qmax_argmax_stream #(.Q_WIDTH(QW), .NUM_ACTIONS(NA), .IDX_WIDTH(IW), .SIGNED_Q(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_q(in_q), .in_legal(in_legal), .busy(busy_s), .out_valid(out_valid_s),
    .out_ready(out_ready), .max_q(max_q_s), .max_idx(max_idx_s),
`ifdef QMAX_LEGAL_COUNT_EN
    .legal_cnt(legal_cnt_s),
`endif
    .none_legal(none_legal_s)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [QW-1:0] q;
    logic [IW-1:0] idx;
    logic          none;
    logic [IW-1:0] cnt;
  } exp_t;

  exp_t uq[$];
  exp_t sq[$];
  exp_t mon_u, mon_s;

  // Directed vectors and hand-computed results (u = unsigned compare, s = signed)
  logic [QW-1:0] vq [7][9];
  logic [NA-1:0] mask [7];
  logic [QW-1:0] eu_q [7];
  logic [QW-1:0] es_q [7];
  logic [IW-1:0] eu_idx [7];
  logic [IW-1:0] es_idx [7];
  logic          e_none [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: compare on every result handshake, after the driver has settled its inputs
  always @(negedge clk) begin
    #1;
    if (rst_n && out_ready && out_valid_u) begin
      if (uq.size() == 0) chk("u_unexpected_result", 32'(1), 32'(0));
      else begin
        mon_u = uq.pop_front();
        chk("u_max_q", 32'(max_q_u), 32'(mon_u.q));
        chk("u_max_idx", 32'(max_idx_u), 32'(mon_u.idx));
        chk("u_none_legal", 32'(none_legal_u), 32'(mon_u.none));
`ifdef QMAX_LEGAL_COUNT_EN
        chk("u_legal_cnt", 32'(legal_cnt_u), 32'(mon_u.cnt));
`endif
        $display("txn unsigned: max_q=0x%05h max_idx=%0d none_legal=%b (exp 0x%05h/%0d/%b)",
                 max_q_u, max_idx_u, none_legal_u, mon_u.q, mon_u.idx, mon_u.none);
      end
    end
    if (rst_n && out_ready && out_valid_s) begin
      if (sq.size() == 0) chk("s_unexpected_result", 32'(1), 32'(0));
      else begin
        mon_s = sq.pop_front();
        chk("s_max_q", 32'(max_q_s), 32'(mon_s.q));
        chk("s_max_idx", 32'(max_idx_s), 32'(mon_s.idx));
        chk("s_none_legal", 32'(none_legal_s), 32'(mon_s.none));
`ifdef QMAX_LEGAL_COUNT_EN
        chk("s_legal_cnt", 32'(legal_cnt_s), 32'(mon_s.cnt));
`endif
        $display("txn signed:   max_q=0x%05h max_idx=%0d none_legal=%b (exp 0x%05h/%0d/%b)",
                 max_q_s, max_idx_s, none_legal_s, mon_s.q, mon_s.idx, mon_s.none);
      end
    end
  end

  task automatic run(input int k, input bit bub, input bit stall, input bit smid, input bit lat);
    exp_t e;
    exp_t es;
    int   i;
    int   g;
    int   t0;
    bit   acc;
    e  = '{q: eu_q[k], idx: eu_idx[k], none: e_none[k], cnt: IW'($countones(mask[k]))};
    es = '{q: es_q[k], idx: es_idx[k], none: e_none[k], cnt: IW'($countones(mask[k]))};
    uq.push_back(e);
    sq.push_back(es);
    out_ready = !stall;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    g = 0;
    while (i < NA && g < 400) begin
      in_valid = !(bub && $urandom_range(0, 2) == 0);
      in_q     = vq[k][i];
      in_legal = mask[k][i];
      start    = smid && (i == 4);
      acc      = in_valid && in_ready_u;
      @(negedge clk);
      start = 1'b0;
      if (acc) i++;
      g++;
    end
    in_valid = 1'b0;
    if (i < NA) chk("beat_accept_timeout", 32'(i), 32'(NA));
    g = 0;
    while (!out_valid_u && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("out_valid_rise", 32'(out_valid_u), 32'(1));
    // Inclusive count: the start cycle is cycle 1, the first out_valid cycle is NA+2
    if (lat) chk("latency_cycles", 32'(cyc - t0 + 1), 32'(NA + 2));
    if (stall) begin
      for (int c = 0; c < 5; c++) begin
        chk("stall_out_valid", 32'(out_valid_u), 32'(1));
        chk("stall_max_q", 32'(max_q_u), 32'(e.q));
        chk("stall_max_idx", 32'(max_idx_u), 32'(e.idx));
        start = (c == 2);
        @(negedge clk);
        start = 1'b0;
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk("valid_drop_after_handshake", 32'(out_valid_u), 32'(0));
    chk("idle_busy", 32'(busy_u), 32'(0));
  endtask

  task automatic reset_mid_eval();
    int i;
    int g;
    bit acc;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    g = 0;
    while (i < 5 && g < 100) begin
      in_valid = 1'b1;
      in_legal = 1'b1;
      in_q     = (i == 1) ? 18'd1000 : 18'd7;
      acc      = in_ready_u;
      @(negedge clk);
      if (acc) i++;
      g++;
    end
    if (i < 5) chk("partial_accept_timeout", 32'(i), 32'(5));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", 32'(in_ready_u), 32'(0));
    chk("rst_mid_busy", 32'(busy_u), 32'(0));
    chk("rst_mid_out_valid", 32'(out_valid_u), 32'(0));
    chk("rst_mid_max_q", 32'(max_q_u), 32'(0));
    chk("rst_mid_max_idx", 32'(max_idx_u), 32'(0));
    chk("rst_mid_none_legal", 32'(none_legal_u), 32'(0));
    chk("rst_mid_s_in_ready", 32'(in_ready_s), 32'(0));
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vq[0] = '{18'd5, 18'd17, 18'd3, 18'd99, 18'd42, 18'd99, 18'd0, 18'd1, 18'd8};
    vq[1] = vq[0];
    vq[2] = vq[0];
    vq[3] = '{18'h3FFFF, 18'h3FFFB, 18'h3FFFE, 18'h3FFF9, 18'h3FFF9, 18'h3FFF9,
              18'h3FFF9, 18'h3FFF9, 18'h3FFF9};
    vq[4] = '{18'd5, 18'h3FFFF, 18'd20, 18'h3FFF0, 18'd7, 18'd20, 18'd1, 18'd0, 18'd2};
    vq[5] = '{18'd1, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7, 18'd8, 18'd9};
    vq[6] = '{18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0};
    mask   = '{9'h1FF, 9'h1D7, 9'h000, 9'h1FF, 9'h1FF, 9'h100, 9'h1FF};
    eu_q   = '{18'd99, 18'd42, 18'd0, 18'h3FFFF, 18'h3FFFF, 18'd9, 18'd0};
    eu_idx = '{4'd3, 4'd4, 4'd0, 4'd0, 4'd1, 4'd8, 4'd0};
    es_q   = '{18'd99, 18'd42, 18'd0, 18'h3FFFF, 18'd20, 18'd9, 18'd0};
    es_idx = '{4'd3, 4'd4, 4'd0, 4'd0, 4'd2, 4'd8, 4'd0};
    e_none = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready_u), 32'(0));
    chk("reset_busy", 32'(busy_u), 32'(0));
    chk("reset_out_valid", 32'(out_valid_u), 32'(0));
    chk("reset_max_q", 32'(max_q_u), 32'(0));
    chk("reset_max_idx", 32'(max_idx_u), 32'(0));
    chk("reset_none_legal", 32'(none_legal_u), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) run(k, 1'b0, 1'b0, 1'b0, k == 0);
    run(0, 1'b1, 1'b1, 1'b1, 1'b0);
    run(4, 1'b1, 1'b1, 1'b0, 1'b0);
    reset_mid_eval();
    run(1, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_u_drained", 32'(uq.size()), 32'(0));
    chk("scoreboard_s_drained", 32'(sq.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
